team_08_lcd_read_ctrl: RTL and testbench

Read-transaction engine for the 8080-style parallel TFT bus driven by the dino game's GPIO pin mux. It complements the game's write-only display path: it issues one command byte, turns the 8-bit data bus around, and strobes `rd` to capture up to four response bytes (panel ID, status, or pixel readback). It sits beside the game core and drives the same `cs`/`cd`/`wr`/`rd`/data pins when the pin mux selects parallel mode.

---
 rtl/team_08_lcd_read_ctrl_if.sv | 49 ++++
 rtl/team_08_lcd_read_ctrl.sv | 170 +++++++++++++++++
 tb/tb_team_08_lcd_read_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/team_08_lcd_read_ctrl_if.sv
// 8080-style TFT read engine bundle: request side plus pad-facing bus.
// slave = engine, master = requester / pad model.
interface team_08_lcd_read_ctrl_if;
  logic        start;
  logic [7:0]  cmd;
  logic [2:0]  nbytes;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        cs;
  logic        cd;
  logic        wr;
  logic        rd;
  logic        busy;
  logic        done;
  logic [31:0] rdata;

  modport slave (
    input  start,
    input  cmd,
    input  nbytes,
    input  data_in,
    output data_out,
    output data_oe,
    output cs,
    output cd,
    output wr,
    output rd,
    output busy,
    output done,
    output rdata
  );

  modport master (
    output start,
    output cmd,
    output nbytes,
    output data_in,
    input  data_out,
    input  data_oe,
    input  cs,
    input  cd,
    input  wr,
    input  rd,
    input  busy,
    input  done,
    input  rdata
  );
endinterface

// File: rtl/team_08_lcd_read_ctrl.sv
// Command write + up to four byte reads on the 8080 TFT bus.
// Define TEAM08_LCD_DUMMY_READ_EN to discard one leading read.
module team_08_lcd_read_ctrl #(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 2
) (
  input logic                    clk,
  input logic                    reset,
  team_08_lcd_read_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_SETUP,
    CMD_WR_LO,
    CMD_WR_HI,
    TURN,
    RD_LO,
    RD_HI,
    FINISH
  } state_t;

  localparam logic [7:0] WL_END = 8'(WR_LOW_CYC - 1);
  localparam logic [7:0] WH_END = 8'(WR_HIGH_CYC - 1);
  localparam logic [7:0] RL_END = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] RH_END = 8'(RD_HIGH_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] n_q;
  logic [2:0] nread;
  logic       dummy;

  logic       take;
  logic [2:0] n_clamp;
  logic       dummy_init;

  // A held start is also taken in FINISH so back-to-back
  // transactions leave cs high for a single cycle.
  assign take = bus.start &&
                (state == IDLE || state == FINISH);

  assign n_clamp = (bus.nbytes > 3'd4) ? 3'd4 : bus.nbytes;

`ifdef TEAM08_LCD_DUMMY_READ_EN
  assign dummy_init = |n_clamp;
`else
  assign dummy_init = 1'b0;
`endif

  // Sequencer; every bus output is set on the state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      n_q          <= '0;
      nread        <= '0;
      dummy        <= 1'b0;
      bus.cs       <= 1'b1;
      bus.cd       <= 1'b1;
      bus.wr       <= 1'b1;
      bus.rd       <= 1'b1;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      bus.done <= 1'b0;
      if (take) begin
        state        <= CMD_SETUP;
        cnt          <= '0;
        n_q          <= n_clamp;
        nread        <= '0;
        dummy        <= dummy_init;
        bus.rdata    <= '0;
        bus.cs       <= 1'b0;
        bus.cd       <= 1'b0;
        bus.wr       <= 1'b1;
        bus.rd       <= 1'b1;
        bus.data_out <= bus.cmd;
        bus.data_oe  <= 1'b1;
        bus.busy     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            bus.busy <= 1'b0;
          end
          CMD_SETUP: begin
            state  <= CMD_WR_LO;
            cnt    <= '0;
            bus.wr <= 1'b0;
          end
          CMD_WR_LO: begin
            if (cnt == WL_END) begin
              state  <= CMD_WR_HI;
              cnt    <= '0;
              bus.wr <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          CMD_WR_HI: begin
            if (cnt == WH_END) begin
              cnt          <= '0;
              bus.cd       <= 1'b1;
              bus.data_out <= '0;
              bus.data_oe  <= 1'b0;
              if (n_q == 3'd0) begin
                state    <= FINISH;
                bus.cs   <= 1'b1;
                bus.done <= 1'b1;
              end else begin
                state <= TURN;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          TURN: begin
            state  <= RD_LO;
            cnt    <= '0;
            bus.rd <= 1'b0;
          end
          RD_LO: begin
            if (cnt == RL_END) begin
              state  <= RD_HI;
              cnt    <= '0;
              bus.rd <= 1'b1;
              if (dummy) begin
                dummy <= 1'b0;
              end else begin
                bus.rdata <= {bus.rdata[23:0],
                              bus.data_in};
                nread     <= nread + 3'd1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          RD_HI: begin
            if (cnt == RH_END) begin
              cnt <= '0;
              if (dummy || nread < n_q) begin
                state  <= RD_LO;
                bus.rd <= 1'b0;
              end else begin
                state    <= FINISH;
                bus.cs   <= 1'b1;
                bus.done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          FINISH: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_team_08_lcd_read_ctrl.sv
// Directed bench for the TFT read engine.
// Latency L counts clock edges starting with the one sampling start.
module tb_team_08_lcd_read_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  team_08_lcd_read_ctrl_if bus ();

  team_08_lcd_read_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TEAM08_LCD_DUMMY_READ_EN
  localparam int DMY = 1;
`else
  localparam int DMY = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] resp [8];
  int         ridx;
  logic [7:0] wr_data;
  logic       wr_cd;
  logic       oe_at_rd;
  int rd_pulses, rd_low, wr_pulses, done_cnt;
  int lat, t, h;

  assign bus.data_in = resp[ridx[2:0]];

  always @(posedge bus.rd) ridx = ridx + 1;

  always @(negedge bus.rd) begin
    rd_pulses = rd_pulses + 1;
    oe_at_rd  = bus.data_oe;
  end

  always @(negedge bus.wr) begin
    wr_pulses = wr_pulses + 1;
    wr_data   = bus.data_out;
    wr_cd     = bus.cd;
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    if (bus.rd === 1'b0)   rd_low   = rd_low + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_resp(input logic [39:0] b,
                          input bit pre);
    int j;
    j = 0;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    if (pre) begin
      resp[0] = 8'hEE;
      j = 1;
    end
    for (int i = 0; i < 5; i++)
      resp[j+i] = b[39-8*i -: 8];
  endtask

  task automatic clr_mon();
    rd_pulses = 0;
    rd_low    = 0;
    wr_pulses = 0;
    done_cnt  = 0;
    ridx      = 0;
    oe_at_rd  = 1'b1;
  endtask

  task automatic txn(input logic [7:0] c,
                     input logic [2:0] nb,
                     output int l);
    clr_mon();
    @(negedge clk);
    bus.cmd    = c;
    bus.nbytes = nb;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    l = 1;
    chk("busy_rise", bus.busy, 1);
    while (!bus.done && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
    if (!bus.done) l = 0;
    @(posedge clk);
    #1;
    chk("done_one", bus.done, 0);
    chk("busy_fall", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b0;
    bus.cmd    = 8'h00;
    bus.nbytes = 3'd0;
    reset      = 1'b0;
    set_resp(40'h0, 1'b0);
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", bus.cs, 1);
    chk("rst_cd", bus.cd, 1);
    chk("rst_wr", bus.wr, 1);
    chk("rst_rd", bus.rd, 1);
    chk("rst_oe", bus.data_oe, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // two-byte read
    set_resp(40'hA53C000000, DMY[0]);
    txn(8'h04, 3'd2, lat);
    chk("n2_lat", lat, 19 + 6*DMY);
    chk("n2_rdata", bus.rdata, 32'h0000A53C);
    chk("n2_rdp", rd_pulses, 2 + DMY);
    chk("n2_rdlow", rd_low, 4*(2 + DMY));
    chk("n2_wrp", wr_pulses, 1);
    chk("n2_wrdat", wr_data, 8'h04);
    chk("n2_turn", oe_at_rd, 0);
    chk("n2_done", done_cnt, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("n2_hold", bus.rdata, 32'h0000A53C);

    // command only
    set_resp(40'h5A5A5A5A5A, 1'b0);
    txn(8'h11, 3'd0, lat);
    chk("n0_lat", lat, 6);
    chk("n0_wrp", wr_pulses, 1);
    chk("n0_wrdat", wr_data, 8'h11);
    chk("n0_cd", wr_cd, 0);
    chk("n0_rdp", rd_pulses, 0);
    chk("n0_rdata", bus.rdata, 0);

    // clamp 7 -> 4
    set_resp(40'h0102030405, DMY[0]);
    txn(8'hDA, 3'd7, lat);
    chk("n7_lat", lat, 31 + 6*DMY);
    chk("n7_rdata", bus.rdata, 32'h01020304);
    chk("n7_rdp", rd_pulses, 4 + DMY);

    // dummy-read stimulus
    set_resp(40'hFF12340000, 1'b0);
    txn(8'hD3, 3'd2, lat);
    chk("dm_lat", lat, 19 + 6*DMY);
    chk("dm_rdata", bus.rdata,
        DMY ? 32'h00001234 : 32'h0000FF12);
    chk("dm_rdp", rd_pulses, 2 + DMY);

    // start pulses while busy
    set_resp(40'h0102030405, DMY[0]);
    clr_mon();
    @(negedge clk);
    bus.cmd    = 8'h04;
    bus.nbytes = 3'd2;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("sb_done", done_cnt, 1);
    chk("sb_busy", bus.busy, 0);
    chk("sb_rdata", bus.rdata, 32'h00000102);

    // start held: back-to-back
    set_resp(40'h0, 1'b0);
    clr_mon();
    @(negedge clk);
    bus.cmd    = 8'h2E;
    bus.nbytes = 3'd1;
    bus.start  = 1'b1;
    t = 0;
    while (!bus.done && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bb_done1", bus.done, 1);
    h = 0;
    t = 0;
    while (t < 10) begin
      @(negedge clk);
      t++;
      if (bus.cs) h++;
      else break;
    end
    bus.start = 1'b0;
    chk("bb_cshigh", h, 1);
    t = 0;
    while (!bus.done && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bb_done2", bus.done, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("bb_cnt", done_cnt, 2);
    chk("bb_busy", bus.busy, 0);

    // reset mid read
    set_resp(40'h1122334455, DMY[0]);
    clr_mon();
    @(negedge clk);
    bus.cmd    = 8'h04;
    bus.nbytes = 3'd4;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t = 0;
    while (rd_pulses < 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mr_inrd", bus.rd, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_cs", bus.cs, 1);
    chk("mr_rd", bus.rd, 1);
    chk("mr_wr", bus.wr, 1);
    chk("mr_cd", bus.cd, 1);
    chk("mr_busy", bus.busy, 0);
    chk("mr_rdata", bus.rdata, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_nodone", done_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    set_resp(40'h7700000000, DMY[0]);
    txn(8'hDB, 3'd1, lat);
    chk("mr_lat", lat, 13 + 6*DMY);
    chk("mr_after", bus.rdata, 32'h00000077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
